// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the CSR side, the sequencing controller and its counter.
// The slave modport is the controller; the master modport is the surrounding environment.
interface counter_seq_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int REPEAT_W = 8
);
    logic                start;
    logic                abort;
    logic                hold;
    logic [WIDTH-1:0]    terminal;
    logic [REPEAT_W-1:0] repeat_n;
    logic                auto_reload;
    logic [WIDTH-1:0]    cnt;
    logic                cnt_en;
    logic                cnt_clr;
    logic                busy;
    logic                tick;
    logic                done;
    logic                err;
    logic                irq;
    logic                irq_ack;
    logic [REPEAT_W-1:0] pass_cnt;

    modport slave (
        input  start, abort, hold, terminal, repeat_n, auto_reload, cnt, irq_ack,
        output cnt_en, cnt_clr, busy, tick, done, err, irq, pass_cnt
    );

    modport master (
        output start, abort, hold, terminal, repeat_n, auto_reload, cnt, irq_ack,
        input  cnt_en, cnt_clr, busy, tick, done, err, irq, pass_cnt
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for one parametric counter: runs N passes of 0..terminal or
// free-runs with auto-reload, reporting per-pass tick, end-of-run done and a sticky irq.
module counter_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int REPEAT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_seq_ctrl_if.slave     bus
);

    localparam int PW = REPEAT_W + 1;
    localparam logic [REPEAT_W-1:0] REP_ONE  = REPEAT_W'(1);
    localparam logic [PW-1:0]       PASS_ONE = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [WIDTH-1:0]    term_r;
    logic [REPEAT_W-1:0] rep_r;
    logic                ar_r;
    logic [REPEAT_W-1:0] pass_cnt_r;
    logic                irq_r;

    logic                accept_s;
    logic                cnt_en_s;
    logic                cnt_clr_s;
    logic                tick_s;
    logic                done_s;
    logic                err_s;
    logic                busy_s;
    logic [PW-1:0]       pass_next_s;
    logic                last_pass_s;

    // One bit wider than the pass counter so the end-of-run compare never wraps.
    assign pass_next_s = {1'b0, pass_cnt_r} + PASS_ONE;
    assign last_pass_s = !ar_r && (pass_next_s >= {1'b0, rep_r});

    // Next-state and output decode from registered state plus hold/abort/cnt.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        tick_s    = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.terminal != {WIDTH{1'b0}}) begin
                        accept_s = 1'b1;
                        state_s  = ST_ARM;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                cnt_clr_s = 1'b1;
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    cnt_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (bus.hold) begin
                    state_s = ST_HOLD;
                end else begin
                    cnt_en_s = 1'b1;
                    if (bus.cnt == term_r) begin
                        cnt_clr_s = 1'b1;
                        tick_s    = 1'b1;
                        if (last_pass_s) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_HOLD: begin
                // Releasing hold costs one frozen cycle; counting resumes from the held value.
                if (bus.abort) begin
                    cnt_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (!bus.hold) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                done_s    = 1'b1;
                cnt_clr_s = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_r != ST_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run configuration, captured only on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            term_r <= {WIDTH{1'b0}};
            rep_r  <= {REPEAT_W{1'b0}};
            ar_r   <= 1'b0;
        end else if (accept_s) begin
            term_r <= bus.terminal;
            rep_r  <= (bus.repeat_n == {REPEAT_W{1'b0}}) ? REP_ONE : bus.repeat_n;
            ar_r   <= bus.auto_reload;
        end else begin
            term_r <= term_r;
            rep_r  <= rep_r;
            ar_r   <= ar_r;
        end
    end

    // Completed-pass counter; wraps naturally in auto-reload runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt_r <= {REPEAT_W{1'b0}};
        end else if (accept_s) begin
            pass_cnt_r <= {REPEAT_W{1'b0}};
        end else if (tick_s) begin
            pass_cnt_r <= pass_cnt_r + REP_ONE;
        end else begin
            pass_cnt_r <= pass_cnt_r;
        end
    end

    // Sticky interrupt; a same-cycle done beats the acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else if (done_s) begin
            irq_r <= 1'b1;
        end else if (bus.irq_ack) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign bus.cnt_en   = cnt_en_s;
    assign bus.cnt_clr  = cnt_clr_s;
    assign bus.busy     = busy_s;
    assign bus.tick     = tick_s;
    assign bus.done     = done_s;
    assign bus.err      = err_s;
    assign bus.irq      = irq_r;
    assign bus.pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed scenarios plus randomized traffic, checked
// cycle by cycle against a run-level behavioural model and a simple counter.
module tb_counter_seq_ctrl;

    localparam int WIDTH    = 8;
    localparam int REPEAT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) ifc ();

    counter_seq_ctrl #(.WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // The counter being sequenced: clear has priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             ifc.cnt <= '0;
        else if (ifc.cnt_clr) ifc.cnt <= '0;
        else if (ifc.cnt_en)  ifc.cnt <= ifc.cnt + 1'b1;
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int tick_q[$];
    int done_at = -1;

    // Behavioural model: run-level view of the controller.
    bit m_busy, m_arm, m_done, m_held, m_ar, m_irq;
    int m_pos, m_term, m_rep, m_passes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_arm = 0; m_done = 0; m_held = 0; m_ar = 0; m_irq = 0;
        m_pos = 0; m_term = 0; m_rep = 0; m_passes = 0;
    endtask

    // One clock cycle: drive, compare at mid-cycle against the model, advance model.
    task automatic cyc(input bit st, input bit ab, input bit hd, input int term,
                       input int rep, input bit ar, input bit ack);
        bit e_en, e_clr, e_tick, e_done, e_err;
        int tv, rv;
        e_en = 0; e_clr = 0; e_tick = 0; e_done = 0; e_err = 0;
        ifc.start = st; ifc.abort = ab; ifc.hold = hd;
        ifc.terminal = term[WIDTH-1:0]; ifc.repeat_n = rep[REPEAT_W-1:0];
        ifc.auto_reload = ar; ifc.irq_ack = ack;
        tv = int'(ifc.terminal);
        rv = int'(ifc.repeat_n);
        #4;
        check("cnt", 64'(ifc.cnt), 64'(m_pos));
        check("irq", 64'(ifc.irq), 64'(m_irq));
        check("pass_cnt", 64'(ifc.pass_cnt), 64'(m_passes % (1 << REPEAT_W)));
        check("busy", 64'(ifc.busy), 64'(m_busy));
        if (ifc.tick === 1'b1) tick_q.push_back(cyc_n);
        if (ifc.done === 1'b1) done_at = cyc_n;
        if (!m_busy) begin
            if (st && tv != 0) begin
                m_busy = 1; m_arm = 1; m_term = tv; m_rep = (rv == 0) ? 1 : rv;
                m_ar = ar; m_passes = 0;
            end else if (st) begin
                e_err = 1;
            end
        end else if (m_arm) begin
            e_clr = 1; m_arm = 0; m_pos = 0; m_held = 0;
            if (ab) m_busy = 0;
        end else if (m_done) begin
            e_done = 1; e_clr = 1; m_done = 0; m_busy = 0; m_pos = 0;
        end else if (ab) begin
            e_clr = 1; m_busy = 0; m_pos = 0;
        end else if (hd || m_held) begin
            // Counting needs hold low in this cycle and the previous one.
            m_held = hd;
        end else begin
            e_en = 1;
            if (m_pos == m_term) begin
                e_tick = 1; e_clr = 1; m_pos = 0; m_passes++;
                if (!m_ar && m_passes >= m_rep) m_done = 1;
            end else begin
                m_pos++;
            end
        end
        m_irq = e_done ? 1'b1 : (ack ? 1'b0 : m_irq);
        check("cnt_en", 64'(ifc.cnt_en), 64'(e_en));
        check("cnt_clr", 64'(ifc.cnt_clr), 64'(e_clr));
        check("tick", 64'(ifc.tick), 64'(e_tick));
        check("done", 64'(ifc.done), 64'(e_done));
        check("err", 64'(ifc.err), 64'(e_err));
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), 0);
    endtask

    task automatic reset_mid();
        #2;
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(ifc.busy), 64'(0));
        check("rst_cnt_en", 64'(ifc.cnt_en), 64'(0));
        check("rst_irq", 64'(ifc.irq), 64'(0));
        check("rst_pass_cnt", 64'(ifc.pass_cnt), 64'(0));
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int t0, rel;
        bit hold_r;
        model_reset();
        ifc.start = 0; ifc.abort = 0; ifc.hold = 0; ifc.terminal = '0;
        ifc.repeat_n = '0; ifc.auto_reload = 0; ifc.irq_ack = 0;
        @(posedge clk); #1;
        check("por_busy", 64'(ifc.busy), 64'(0));
        check("por_irq", 64'(ifc.irq), 64'(0));
        check("por_cnt_en", 64'(ifc.cnt_en), 64'(0));
        rst = 1'b1;
        idle(2);

        // Basic run: terminal 4, three passes; a start mid-run must be ignored.
        tick_q.delete(); done_at = -1; t0 = cyc_n;
        cyc(1, 0, 0, 4, 3, 0, 0);
        for (int i = 0; i < 22; i++) cyc(i == 4, 0, 0, 7, 1, 0, 0);
        check("basic_ticks", 64'(tick_q.size()), 64'(3));
        if (tick_q.size() == 3) begin
            check("basic_tick1", 64'(tick_q[0] - t0), 64'(6));
            check("basic_tick2", 64'(tick_q[1] - t0), 64'(11));
            check("basic_tick3", 64'(tick_q[2] - t0), 64'(16));
        end
        check("basic_done", 64'(done_at - t0), 64'(17));
        check("basic_pass", 64'(ifc.pass_cnt), 64'(3));
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Hold at cnt=3 for six cycles, then the pass completes 7 enabled cycles later.
        tick_q.delete();
        cyc(1, 0, 0, 9, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        rel = cyc_n;
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        check("hold_ticks", 64'(tick_q.size()), 64'(1));
        if (tick_q.size() == 1) check("hold_tick_at", 64'(tick_q[0] - rel), 64'(7));

        // Abort in the second pass together with hold; irq stays set.
        done_at = -1;
        cyc(1, 0, 0, 4, 3, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        idle(3);
        check("abort_no_done", 64'(done_at), 64'(-1));
        check("abort_irq", 64'(ifc.irq), 64'(1));
        // Abort from HOLD and from ARM.
        cyc(1, 0, 0, 5, 2, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0, 0, 0); idle(2);
        cyc(1, 0, 0, 5, 2, 0, 0); cyc(0, 1, 0, 0, 0, 0, 1); idle(2);

        // repeat_n=0 runs one pass; terminal=0 is rejected.
        tick_q.delete();
        cyc(1, 0, 0, 2, 0, 0, 0); idle(8);
        check("rep0_ticks", 64'(tick_q.size()), 64'(1));
        cyc(1, 0, 0, 0, 2, 0, 0);
        check("term0_busy", 64'(ifc.busy), 64'(0));
        idle(1);

        // Auto-reload: tick every two cycles, pass_cnt wraps, stopped only by abort.
        tick_q.delete(); done_at = -1;
        cyc(1, 0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        check("ar_ticks", 64'(tick_q.size()), 64'(7));
        check("ar_no_done", 64'(done_at), 64'(-1));

        // irq race: ack during the done cycle loses, ack afterwards clears.
        cyc(1, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("race_irq_set", 64'(ifc.irq), 64'(1));
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("race_irq_clr", 64'(ifc.irq), 64'(0));

        // Asynchronous reset mid-run with irq set.
        cyc(1, 0, 0, 1, 1, 0, 0); idle(5);
        cyc(1, 0, 0, 9, 2, 0, 0); idle(5);
        reset_mid();
        idle(2);

        // Randomized traffic.
        hold_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) hold_r = !hold_r;
            if (i == 1500) reset_mid();
            cyc(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 49) == 0), hold_r,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 3) == 0));
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the parametric counter. It drives the counter's en/clr inputs and watches its cnt output, producing programmable timed runs: N passes of 0..terminal, or free-running auto-reload. Outputs per-pass tick, end-of-run done, and a sticky interrupt. It sits between the control/CSR logic and one counter instance.

Parameters:
WIDTH, 32, counter width; must match the counter's cnt width
REPEAT_W, 8, width of the repeat-count and pass-counter fields

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a run; sampled in IDLE only
abort  input  1  terminate the run immediately
hold  input  1  level; freezes the counter while high in RUN
terminal  input  WIDTH  last count value of a pass; latched on accepted start
repeat_n  input  REPEAT_W  number of passes; latched on accepted start; 0 treated as 1
auto_reload  input  1  1 = unlimited passes; latched on accepted start
cnt  input  WIDTH  counter value, fed back from the counter
cnt_en  output  1  counter enable
cnt_clr  output  1  counter synchronous clear
busy  output  1  state != IDLE
tick  output  1  one-cycle pulse at each terminal event
done  output  1  one-cycle pulse at end of run
err  output  1  one-cycle pulse when start is rejected
irq  output  1  sticky, set by done
irq_ack  input  1  clears irq
pass_cnt  output  REPEAT_W  passes completed in the current run

Behaviour:
- Counter contract: on each clk edge, clr=1 sets cnt to 0 (clr has priority); otherwise en=1 increments cnt.
- States: IDLE, ARM, RUN, HOLD, DONE. Reset (rst=0, async): state=IDLE, irq=0, pass_cnt=0, latched config=0. All combinational outputs are then 0.
- IDLE:
  - start=1 and terminal!=0: latch term_q, rep_q (0→1) and ar_q; clear pass_cnt; go to ARM.
  - start=1 and terminal==0: err=1 for that cycle; stay in IDLE.
- ARM: one cycle. cnt_clr=1, cnt_en=0, then go to RUN. cnt therefore reads 0 in the first RUN cycle.
- RUN:
  - cnt_en = !hold.
  - Terminal event = RUN && !hold && !abort && cnt==term_q. In that cycle: cnt_clr=1, tick=1, pass_cnt increments.
  - After a terminal event, go to DONE if !ar_q && pass_cnt+1 >= rep_q; otherwise stay in RUN.
  - Each pass is exactly term_q+1 enabled cycles.
  - hold=1 (no abort): cnt_en=0, no terminal check, go to HOLD.
- HOLD: cnt_en=0, cnt_clr=0. When hold=0, go to RUN; cnt resumes from the held value on the next cycle.
- abort, in ARM, RUN or HOLD: highest priority. cnt_clr=1, cnt_en=0, tick=0, go to IDLE. No done, no irq; pass_cnt keeps its value.
- DONE: one cycle. done=1, cnt_clr=1, cnt_en=0, then go to IDLE. pass_cnt holds the final value until the next accepted start.
- start outside IDLE: ignored, with no err.
- Config inputs are ignored except on the cycle start is accepted.
- pass_cnt wraps modulo 2^REPEAT_W. This only matters with auto_reload.
- irq (registered): set on the edge after done=1. Cleared by irq_ack. If set and ack fall on the same cycle, set wins.
- Combinational outputs (cnt_en, cnt_clr, tick, done, err, busy) are decoded from the registered state plus hold/abort/cnt. There is no combinational path from start to cnt_en.

Test Plan:
- Reset: drive rst=0 mid-RUN → state IDLE, cnt_en=0, irq=0 and pass_cnt=0 immediately, without waiting for a clk edge.
- Basic run, terminal=4, repeat_n=3, auto_reload=0: pulse start → ARM for 1 cycle; cnt goes 0..4 three times; tick in RUN cycles 5, 10 and 15; done on the cycle after the third tick; pass_cnt=3; irq=1 until irq_ack.
- Hold: terminal=9; raise hold at cnt=3 for 6 cycles → cnt stays at 3, no tick; after release, tick occurs exactly 7 enabled cycles later.
- Abort and clamps:
  - Abort during the second pass → cnt_clr=1 that cycle, back to IDLE, done=0, irq unchanged.
  - Hold and abort asserted together → abort wins.
- Boundaries:
  - repeat_n=0 runs exactly one pass.
  - terminal=0 start → err pulse, busy stays 0.
  - start while busy is ignored.
  - auto_reload=1, terminal=1, REPEAT_W=2 → tick every 2 cycles; pass_cnt wraps 3→0; done never fires until abort.
- irq race: hold irq_ack high during the done cycle's following edge → irq=1 (set wins); ack on the next cycle → irq=0.
